kb_event_sched: RTL and testbench
=================================

# kb_event_sched

Keyboard event scheduler between the input sources (PS/2 decoder, gamepad numpad bits) and `vp_keymap`. It merges both sources into one ordered event stream through a small FIFO, then presents one event at a time to the keymap. Each event is held for a minimum number of CPU-enable ticks, so the console's keyboard scan always sees a press before its release. Gamepad keys are reconciled against a reported-state vector, so a key cannot be left stuck down.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: event queue depth; power of two, ≥2.
- `HOLD_TICKS`, 16: minimum `tick_i` pulses an issued event is held before the next issue; ≥1.

Ports:
- `clk_sys`  in  1  system clock; the block's only clock.
- `reset`  in  1  synchronous, active-high reset.
- `tick_i`  in  1  hold-time strobe; tied to `clk_cpu_en`.
- `ps2_valid_i`  in  1  one-cycle strobe: new PS/2 event.
- `ps2_ascii_i`  in  8  ASCII code of the PS/2 event.
- `ps2_release_i`  in  1  1 = key release, 0 = key press.
- `joy_numpad_i`  in  10  gamepad keys, level, 1 = pressed; bit0..8 = "1".."9", bit9 = "0".
- `rx_data_ready_o`  out  1  one-cycle issue strobe to `vp_keymap`.
- `rx_ascii_o`  out  8  issued ASCII code; stable between issues.
- `rx_released_o`  out  1  issued release flag; stable between issues.
- `busy_o`  out  1  scheduler in ISSUE or HOLD.
- `overflow_o`  out  1  sticky; set when a PS/2 event is dropped.
- `fifo_level_o`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Event format: {released, ascii[7:0]}, 9 bits.
- Enqueue arbitration: at most one write per cycle.
  - PS/2 has priority. If `ps2_valid_i` is high and the FIFO is not full, write {ps2_release_i, ps2_ascii_i}.
  - If `ps2_valid_i` is high and the FIFO is full, drop the event and set `overflow_o`.
- Gamepad reconciliation:
  - Register `rep[9:0]` holds the key state last enqueued; reset value 0.
  - In a cycle with no PS/2 write and the FIFO not full, select the lowest index i where `joy_numpad_i[i] != rep[i]`.
  - Enqueue {~joy_numpad_i[i], ascii(i)} and toggle `rep[i]`.
  - Gamepad changes are never dropped; they stay pending until accepted.
  - Pulses shorter than the wait collapse: a press then release of the same bit before acceptance produces no event.
- Full-and-pop: when the FIFO is full and being popped in the same cycle, the write is accepted.
- Scheduler FSM:
  - IDLE → ISSUE when the FIFO is non-empty. Pop the head and latch it into `rx_ascii_o`/`rx_released_o`.
  - ISSUE (1 cycle): assert `rx_data_ready_o`, load the hold counter with `HOLD_TICKS`, go to HOLD.
  - HOLD: decrement the counter on each `tick_i`. When the counter reaches 0, go to IDLE.
  - The hold rule is uniform for press and release events.
- Reset values: FIFO empty, `rep` = 0, FSM in IDLE, counter 0, `rx_data_ready_o` = 0, `rx_ascii_o` = 8'h00, `rx_released_o` = 1, `busy_o` = 0, `overflow_o` = 0, `fifo_level_o` = 0.
- Reset asserted mid-HOLD: the pending queue is discarded. `rx_released_o` returning to 1 releases any held key. `vp_keymap` is reset by the same `reset`.

## Timing
- PS/2 event into an idle, empty block:
  - FIFO write at edge N+1.
  - Pop/latch at edge N+2.
  - `rx_data_ready_o` high during the cycle after edge N+2: 2 cycles of latency.
- Gamepad edge: the same as PS/2, plus 1 cycle for the input-compare register, provided `ps2_valid_i` is idle.
- Minimum spacing between `rx_data_ready_o` pulses: 2 cycles plus the time for `HOLD_TICKS` ticks. A tick coincident with the ISSUE cycle is not counted.
- `rx_ascii_o`/`rx_released_o` change only on the edge that enters ISSUE. They are valid in the strobe cycle and held afterwards.
- `fifo_level_o` is registered and reflects the write and pop of the previous edge.

## Structure
- Package `kb_pkg`:
  - `kb_event_t` struct {released, ascii}.
  - Gamepad ASCII table `JOY_ASCII[10]`.
  - FSM enum `sched_state_t` {IDLE, ISSUE, HOLD}.
- Sub-module `kb_event_fifo`:
  - Synchronous single-clock FIFO, parameterised by depth and width.
  - Ports: write/full, pop/empty, level.
  - Read and write pointers wrap modulo `FIFO_DEPTH`; count-based full/empty.
- Top level contains: enqueue arbiter, `rep` register with priority encoder, hold counter, FSM.

## Test plan
- Single PS/2 event: press "a" (8'h61), HOLD_TICKS=4, tick every 8 cycles → strobe 2 cycles later with ascii 8'h61, released 0. A release of "a" sent immediately after is issued no earlier than 4 ticks later with released 1.
- Gamepad bits 0 and 3 rise in the same cycle → press events "1" then "4", in index order. Dropping both bits → releases "1" then "4". Final `rep` = 0.
- Contention: `ps2_valid_i` held for 3 consecutive cycles while bit 9 rises → three PS/2 events queued first, then press "0". No loss, `overflow_o` stays 0.
- Overflow: FIFO_DEPTH=8, scheduler stalled in HOLD, 10 PS/2 events → level saturates at 8, `overflow_o` = 1, the first 8 are issued in order, events 9–10 are absent.
- Glitch: bit 2 pulses high for 1 cycle while the FIFO is full → no event for "3", `rep[2]` = 0.
- Reset mid-HOLD with 3 events queued → the next cycle shows level 0, IDLE, `rx_released_o` = 1, `rx_data_ready_o` = 0, and no strobes afterwards.

Source files
------------

// File: rtl/kb_pkg.sv
// Shared types and tables for the keyboard event scheduler.
// Event bundle, gamepad key codes and scheduler states.
package kb_pkg;

  localparam int JOY_KEYS = 10;

  typedef struct packed {
    logic       released;
    logic [7:0] ascii;
  } kb_event_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } sched_state_t;

  localparam logic [7:0] JOY_ASCII [JOY_KEYS] = '{
    8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
    8'h36, 8'h37, 8'h38, 8'h39, 8'h30
  };

  // Lowest set bit wins so simultaneous changes leave in index order
  function automatic logic [3:0] first_set(
    input logic [JOY_KEYS-1:0] v
  );
    first_set = '0;
    for (int i = JOY_KEYS - 1; i >= 0; i--)
      if (v[i]) first_set = 4'(i);
  endfunction

endpackage

// File: rtl/kb_event_fifo.sv
// Single-clock event queue with count-based full/empty.
// Pointers wrap naturally because the depth is a power of two.
module kb_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk_sys) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kb_event_sched.sv
// Merges PS/2 and gamepad key events and issues them to the
// keymap one at a time, each held for a minimum number of ticks.
module kb_event_sched
  import kb_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int HOLD_TICKS = 16
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          tick_i,
  input  logic                          ps2_valid_i,
  input  logic [7:0]                    ps2_ascii_i,
  input  logic                          ps2_release_i,
  input  logic [9:0]                    joy_numpad_i,
  output logic                          rx_data_ready_o,
  output logic [7:0]                    rx_ascii_o,
  output logic                          rx_released_o,
  output logic                          busy_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int CW = $clog2(HOLD_TICKS + 1);

  sched_state_t  state;
  logic [CW-1:0] hold_cnt;

  logic [JOY_KEYS-1:0] joy_q;
  logic [JOY_KEYS-1:0] rep;
  logic [JOY_KEYS-1:0] diff;
  logic [3:0]          idx;

  kb_event_t wr_evt;
  kb_event_t head;
  logic      full;
  logic      empty;
  logic      pop;
  logic      can_wr;
  logic      ps2_wr;
  logic      joy_wr;

  assign diff   = joy_q ^ rep;
  assign idx    = first_set(diff);
  assign pop    = (state == IDLE) && !empty;
  assign can_wr = !full || pop;
  assign ps2_wr = ps2_valid_i && can_wr;
  assign joy_wr = !ps2_valid_i && can_wr && (|diff);

  always_comb begin
    wr_evt = '{released: ps2_release_i, ascii: ps2_ascii_i};
    if (!ps2_valid_i)
      wr_evt = '{released: ~joy_q[idx], ascii: JOY_ASCII[idx]};
  end

  kb_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(kb_event_t))
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .wr_en   (ps2_wr || joy_wr),
    .wr_data (wr_evt),
    .full    (full),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (empty),
    .level   (fifo_level_o)
  );

  // rep tracks what was enqueued, so a short pulse collapses to nothing
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      joy_q      <= '0;
      rep        <= '0;
      overflow_o <= 1'b0;
    end else begin
      joy_q <= joy_numpad_i;
      if (joy_wr) rep[idx] <= ~rep[idx];
      if (ps2_valid_i && !can_wr) overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state           <= IDLE;
      hold_cnt        <= '0;
      rx_data_ready_o <= 1'b0;
      rx_ascii_o      <= 8'h00;
      rx_released_o   <= 1'b1;
      busy_o          <= 1'b0;
    end else begin
      rx_data_ready_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!empty) begin
            state           <= ISSUE;
            rx_ascii_o      <= head.ascii;
            rx_released_o   <= head.released;
            rx_data_ready_o <= 1'b1;
            busy_o          <= 1'b1;
          end
        end
        ISSUE: begin
          hold_cnt <= CW'(HOLD_TICKS);
          state    <= HOLD;
        end
        HOLD: begin
          if (tick_i) begin
            if (hold_cnt <= CW'(1)) begin
              hold_cnt <= '0;
              state    <= IDLE;
              busy_o   <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt - CW'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kb_event_sched.sv
// Scoreboard bench for kb_event_sched: issued events are matched
// against a queue filled as stimulus is driven.
module tb_kb_event_sched;

  localparam int DEPTH = 8;
  localparam int HOLD  = 4;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       tick_i = 1'b0;
  logic       ps2_valid_i = 1'b0;
  logic [7:0] ps2_ascii_i = 8'h00;
  logic       ps2_release_i = 1'b0;
  logic [9:0] joy_numpad_i = '0;
  logic       rx_data_ready_o;
  logic [7:0] rx_ascii_o;
  logic       rx_released_o;
  logic       busy_o;
  logic       overflow_o;
  logic [3:0] fifo_level_o;

  kb_event_sched #(
    .FIFO_DEPTH (DEPTH),
    .HOLD_TICKS (HOLD)
  ) dut (
    .clk_sys         (clk_sys),
    .reset           (reset),
    .tick_i          (tick_i),
    .ps2_valid_i     (ps2_valid_i),
    .ps2_ascii_i     (ps2_ascii_i),
    .ps2_release_i   (ps2_release_i),
    .joy_numpad_i    (joy_numpad_i),
    .rx_data_ready_o (rx_data_ready_o),
    .rx_ascii_o      (rx_ascii_o),
    .rx_released_o   (rx_released_o),
    .busy_o          (busy_o),
    .overflow_o      (overflow_o),
    .fifo_level_o    (fifo_level_o)
  );

  always #5 clk_sys = ~clk_sys;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [8:0] sb [$];
  int         n_strobe = 0;
  int         ticks = 0;
  bit         have_prev = 0;
  bit         tick_en = 1;
  int         tcnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  initial forever begin
    @(posedge clk_sys);
    #1;
    tcnt++;
    tick_i = tick_en && (tcnt % 8 == 0);
  end

  always @(negedge clk_sys) begin
    if (reset) begin
      ticks = 0;
      have_prev = 0;
    end else if (rx_data_ready_o) begin
      n_strobe++;
      chk("sb_has_entry", 32'(sb.size() != 0), 1);
      if (sb.size() != 0)
        chk("event", {rx_released_o, rx_ascii_o}, sb.pop_front());
      if (have_prev)
        chk("spacing", 32'(ticks >= HOLD), 1);
      have_prev = 1;
      ticks = 0;
    end else if (tick_i) begin
      ticks++;
    end
  end

  task automatic ps2_drive(input logic [7:0] a,
                           input logic r,
                           input bit push);
    @(posedge clk_sys);
    #1;
    ps2_valid_i = 1'b1;
    ps2_ascii_i = a;
    ps2_release_i = r;
    if (push) sb.push_back({r, a});
  endtask

  task automatic ps2_idle();
    @(posedge clk_sys);
    #1;
    ps2_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk_sys);
      #1;
      done = (sb.size() == 0) && !busy_o && (fifo_level_o == 0);
    end
    chk(tag, 32'(done), 1);
  endtask

  initial begin
    int saved;
    bit ok;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_ready", rx_data_ready_o, 0);
    chk("rst_ascii", rx_ascii_o, 8'h00);
    chk("rst_released", rx_released_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_level", fifo_level_o, 0);
    reset = 1'b0;

    // Single press then release; strobe two edges after the write
    ps2_drive(8'h61, 1'b0, 1);
    ps2_drive(8'h61, 1'b1, 1);
    @(posedge clk_sys);
    #1;
    ps2_valid_i = 1'b0;
    chk("lat_ready", rx_data_ready_o, 1);
    chk("lat_ascii", rx_ascii_o, 8'h61);
    chk("lat_rel", rx_released_o, 0);
    drain("drain_single");

    // Gamepad bits 0 and 3 together, then both released
    @(posedge clk_sys);
    #1;
    joy_numpad_i = 10'b00_0000_1001;
    sb.push_back({1'b0, 8'h31});
    sb.push_back({1'b0, 8'h34});
    drain("drain_joy_press");
    joy_numpad_i = '0;
    sb.push_back({1'b1, 8'h31});
    sb.push_back({1'b1, 8'h34});
    drain("drain_joy_rel");
    chk("rep_zero", dut.rep, 0);

    // PS/2 burst contends with gamepad bit 9
    ps2_drive(8'h10, 1'b0, 1);
    joy_numpad_i = 10'b10_0000_0000;
    ps2_drive(8'h11, 1'b0, 1);
    ps2_drive(8'h12, 1'b1, 1);
    sb.push_back({1'b0, 8'h30});
    ps2_idle();
    drain("drain_contend");
    chk("contend_ovf", overflow_o, 0);
    joy_numpad_i = '0;
    sb.push_back({1'b1, 8'h30});
    drain("drain_joy0_rel");

    // Overflow with the scheduler stalled in HOLD
    tick_en = 0;
    ps2_drive(8'h60, 1'b0, 1);
    ps2_idle();
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk_sys);
      #1;
      ok = (sb.size() == 0) && busy_o;
    end
    chk("stall_hold", 32'(ok), 1);
    for (int k = 0; k < 10; k++)
      ps2_drive(8'h41 + 8'(k), 1'b0, k < DEPTH);
    ps2_idle();
    @(posedge clk_sys);
    #1;
    chk("ovf_level", fifo_level_o, DEPTH);
    chk("ovf_flag", overflow_o, 1);

    // One-cycle gamepad glitch while full leaves no trace
    joy_numpad_i = 10'b00_0000_0100;
    @(posedge clk_sys);
    #1;
    joy_numpad_i = '0;
    repeat (5) @(posedge clk_sys);
    #1;
    chk("glitch_level", fifo_level_o, DEPTH);
    chk("glitch_rep2", dut.rep[2], 0);
    tick_en = 1;
    drain("drain_ovf");
    chk("ovf_sticky", overflow_o, 1);

    // Reset in HOLD discards the queued events
    tick_en = 0;
    ps2_drive(8'h70, 1'b0, 1);
    ps2_drive(8'h71, 1'b0, 0);
    ps2_drive(8'h72, 1'b0, 0);
    ps2_drive(8'h73, 1'b0, 0);
    ps2_idle();
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk_sys);
      #1;
      ok = (fifo_level_o == 3) && busy_o && (sb.size() == 0);
    end
    chk("pre_rst_q3", 32'(ok), 1);
    chk("pre_rst_rel", rx_released_o, 0);
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    chk("mid_rst_level", fifo_level_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_rel", rx_released_o, 1);
    chk("mid_rst_ready", rx_data_ready_o, 0);
    chk("mid_rst_ovf", overflow_o, 0);
    tick_en = 1;
    saved = n_strobe;
    repeat (200) @(posedge clk_sys);
    #1;
    chk("no_strobe_after_rst", n_strobe, saved);
    chk("sb_empty_end", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
